forward_hazard_window: RTL and testbench
========================================

Name: forward_hazard_window

Overview:
- Per-table write-forwarding window for the multi-table cuckoo hash pipeline.
- Keeps the last FORWARD_DEPTH committed writes of every table and patches stale memory read data (key, data, valid bit) with the newest in-flight write to the same address.
- Sits between the table RAM read ports and the insert/lookup decision stage.
- Generalised successor of the fixed two-cycle forward updater: arbitrary depth, optional same-cycle bypass, flush, warm-up tracking and per-table hit reporting.

Parameters:
- NUM_TABLES, 4, number of hash tables (≥1).
- FORWARD_DEPTH, 3, history slots per table = RAM read latency in clk_en cycles (≥1).
- ADR_WIDTH, 4, hash address width, compared full width.
- KEY_WIDTH, 8, key width.
- DATA_WIDTH, 16, data width.
- BYPASS_CURRENT, 1, 1 = a write presented in the same cycle also forwards; 0 = only history slots forward.
- HIT_CNT_WIDTH, 8, hit counter width (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  global stall; 0 freezes all state.
- flush_i  in  1  clears history and warm-up count.
- rd_valid_i  in  1  read results below are meaningful this cycle.
- rd_adr_i[NUM_TABLES]  in  ADR_WIDTH  address read from each table.
- rd_key_i[NUM_TABLES]  in  KEY_WIDTH  key read from RAM.
- rd_data_i[NUM_TABLES]  in  DATA_WIDTH  data read from RAM.
- rd_entry_valid_i[NUM_TABLES]  in  1  valid bit read from RAM.
- wr_en_i[NUM_TABLES]  in  1  write committed to table t this cycle.
- wr_adr_i[NUM_TABLES]  in  ADR_WIDTH  write address.
- wr_key_i[NUM_TABLES]  in  KEY_WIDTH  written key.
- wr_data_i[NUM_TABLES]  in  DATA_WIDTH  written data.
- wr_entry_valid_i[NUM_TABLES]  in  1  written valid bit (0 = delete/evict).
- cor_valid_o  out  1  registered copy of rd_valid_i.
- cor_key_o[NUM_TABLES]  out  KEY_WIDTH  corrected key.
- cor_data_o[NUM_TABLES]  out  DATA_WIDTH  corrected data.
- cor_entry_valid_o[NUM_TABLES]  out  1  corrected valid bit.
- fwd_hit_o[NUM_TABLES]  out  1  table t output came from forwarding, not RAM.
- warm_o  out  1  history covers a full FORWARD_DEPTH window.

Behaviour:
- Reset (async, reset=0):
  - All history slots invalid; fill counter 0.
  - All outputs 0, including warm_o.
- History:
  - Per table, a shift register of FORWARD_DEPTH slots {en, adr, key, data, ev}; slot 0 is newest.
  - On each clk edge with clk_en=1: slot k+1 <= slot k; slot 0 <= {wr_en_i, wr_adr_i, wr_key_i, wr_data_i, wr_entry_valid_i}.
  - The history shifts every enabled cycle, so slot index = write age in cycles. An idle cycle inserts en=0.
- Correction (combinational select, registered output):
  - For table t, the candidate list in priority order is: current write (only if BYPASS_CURRENT=1), then slot 0 … slot FORWARD_DEPTH-1.
  - The first candidate with en=1 and adr == rd_adr_i[t] supplies key/data/ev, and fwd_hit=1.
  - If no candidate matches, RAM values pass through and fwd_hit=0.
  - A delete (ev=0) is forwarded like any other write; key/data are forwarded unchanged.
- Output timing:
  - Latency is 1 enabled cycle. On clk_en=1, the output registers load the selection, and cor_valid_o <= rd_valid_i.
  - When rd_valid_i=0, the selection is still loaded but must not be consumed.
- Stall: clk_en=0 holds history, fill counter and outputs; wr_en_i is ignored (the writer must also stall).
- Flush (flush_i=1 at a clk edge, regardless of clk_en):
  - All slots' en cleared, cor_valid_o <= 0, fwd_hit_o <= 0, fill counter <= 0.
  - If clk_en=1 and wr_en_i[t]=1 in the same cycle, slot 0 of table t still captures that write and the fill counter becomes 1. The RAM is written, so the write must remain visible.
- Fill counter:
  - Width $clog2(FORWARD_DEPTH+1); increments per enabled cycle and saturates at FORWARD_DEPTH.
  - warm_o = (count == FORWARD_DEPTH), registered.
- Tables are fully independent; no cross-table address compare. Shift moves appear as a delete in table t plus a write in table t+1.
- FORWARD_DEPTH=1 and NUM_TABLES=1 must elaborate and work.

Optional Feature:
- Macro FWD_HIT_COUNT_EN.
- When defined:
  - Adds output fwd_hit_cnt_o[NUM_TABLES] (HIT_CNT_WIDTH bits).
  - Counter t increments on each enabled cycle where rd_valid_i=1 and table t hits, saturating at all-ones.
  - Cleared by reset and flush_i; held when clk_en=0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/warm-up: release reset, clk_en=1 for 3 cycles with no writes -> all outputs 0 until then, warm_o=1 after the 3rd enabled edge.
- Age priority:
  - Table 1 writes adr 5 with key 0x11 at cycle n, then key 0x22 at n+1.
  - At n+2, read adr 5 with RAM key 0x00 -> cor_key_o[1]=0x22, fwd_hit_o[1]=1 at n+3.
- Window expiry: single write adr 3 data 0xBEEF, read adr 3 exactly FORWARD_DEPTH+1 cycles later with RAM 0x1234 -> output 0x1234, fwd_hit_o=0.
- Bypass and delete:
  - BYPASS_CURRENT=1: same-cycle write adr 7 ev=0 while reading adr 7 with RAM ev=1 -> cor_entry_valid_o=0, hit=1.
  - Rerun with BYPASS_CURRENT=0 -> ev=1, hit=0.
- Stall and flush:
  - Hold clk_en=0 for 5 cycles mid-window -> outputs and warm_o frozen, and a forwarded hit still occurs after resume.
  - Assert flush_i with a concurrent write adr 2 -> only adr 2 forwards afterwards, warm_o=0.
- Async reset mid-operation: drop reset between edges with history full -> outputs 0 immediately; with FWD_HIT_COUNT_EN, counters read 0, and 300 consecutive hits saturate the counter at 255.

Source files
------------

// File: rtl/forward_hazard_window_if.sv
// Read/write/correction bus of the forward hazard window.
// With FWD_HIT_COUNT_EN defined the bus also carries per-table forward hit counters.
interface forward_hazard_window_if #(
  parameter int unsigned NUM_TABLES    = 4,
  parameter int unsigned ADR_WIDTH     = 4,
  parameter int unsigned KEY_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH    = 16
`ifdef FWD_HIT_COUNT_EN
  ,
  parameter int unsigned HIT_CNT_WIDTH = 8
`endif
);
  logic                  clk_en;
  logic                  flush_i;
  logic                  rd_valid_i;
  logic [ADR_WIDTH-1:0]  rd_adr_i          [NUM_TABLES];
  logic [KEY_WIDTH-1:0]  rd_key_i          [NUM_TABLES];
  logic [DATA_WIDTH-1:0] rd_data_i         [NUM_TABLES];
  logic                  rd_entry_valid_i  [NUM_TABLES];
  logic                  wr_en_i           [NUM_TABLES];
  logic [ADR_WIDTH-1:0]  wr_adr_i          [NUM_TABLES];
  logic [KEY_WIDTH-1:0]  wr_key_i          [NUM_TABLES];
  logic [DATA_WIDTH-1:0] wr_data_i         [NUM_TABLES];
  logic                  wr_entry_valid_i  [NUM_TABLES];
  logic                  cor_valid_o;
  logic [KEY_WIDTH-1:0]  cor_key_o         [NUM_TABLES];
  logic [DATA_WIDTH-1:0] cor_data_o        [NUM_TABLES];
  logic                  cor_entry_valid_o [NUM_TABLES];
  logic                  fwd_hit_o         [NUM_TABLES];
  logic                  warm_o;
`ifdef FWD_HIT_COUNT_EN
  logic [HIT_CNT_WIDTH-1:0] fwd_hit_cnt_o  [NUM_TABLES];
`endif

  // Pipeline side driving reads/writes and consuming corrected data
  modport master (
    output clk_en, flush_i, rd_valid_i, rd_adr_i, rd_key_i, rd_data_i, rd_entry_valid_i,
           wr_en_i, wr_adr_i, wr_key_i, wr_data_i, wr_entry_valid_i,
    input  cor_valid_o, cor_key_o, cor_data_o, cor_entry_valid_o, fwd_hit_o, warm_o
`ifdef FWD_HIT_COUNT_EN
    , input fwd_hit_cnt_o
`endif
  );

  // Forwarding window side
  modport slave (
    input  clk_en, flush_i, rd_valid_i, rd_adr_i, rd_key_i, rd_data_i, rd_entry_valid_i,
           wr_en_i, wr_adr_i, wr_key_i, wr_data_i, wr_entry_valid_i,
    output cor_valid_o, cor_key_o, cor_data_o, cor_entry_valid_o, fwd_hit_o, warm_o
`ifdef FWD_HIT_COUNT_EN
    , output fwd_hit_cnt_o
`endif
  );
endinterface

// File: rtl/forward_hazard_window.sv
// Per-table write-forwarding window: patches stale RAM read data with the
// newest write still in flight (last FORWARD_DEPTH enabled cycles, plus the
// current write when BYPASS_CURRENT=1).
// Optional feature macro: FWD_HIT_COUNT_EN adds saturating per-table hit counters.
module forward_hazard_window #(
  parameter int unsigned NUM_TABLES     = 4,
  parameter int unsigned FORWARD_DEPTH  = 3,
  parameter int unsigned ADR_WIDTH      = 4,
  parameter int unsigned KEY_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BYPASS_CURRENT = 1,
  parameter int unsigned HIT_CNT_WIDTH  = 8
) (
  input logic                    clk,
  input logic                    reset,
  forward_hazard_window_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FORWARD_DEPTH + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(FORWARD_DEPTH);

  if (NUM_TABLES == 0 || FORWARD_DEPTH == 0 || HIT_CNT_WIDTH == 0) begin : g_bad_params
    $error("forward_hazard_window: NUM_TABLES, FORWARD_DEPTH and HIT_CNT_WIDTH must be nonzero");
  end

  // History: index 0 is the newest slot, index = write age in enabled cycles
  logic                  hist_en   [NUM_TABLES][FORWARD_DEPTH];
  logic [ADR_WIDTH-1:0]  hist_adr  [NUM_TABLES][FORWARD_DEPTH];
  logic [KEY_WIDTH-1:0]  hist_key  [NUM_TABLES][FORWARD_DEPTH];
  logic [DATA_WIDTH-1:0] hist_data [NUM_TABLES][FORWARD_DEPTH];
  logic                  hist_ev   [NUM_TABLES][FORWARD_DEPTH];

  logic [KEY_WIDTH-1:0]  sel_key   [NUM_TABLES];
  logic [DATA_WIDTH-1:0] sel_data  [NUM_TABLES];
  logic                  sel_ev    [NUM_TABLES];
  logic                  sel_hit   [NUM_TABLES];

  logic                  cor_valid_q;
  logic [KEY_WIDTH-1:0]  cor_key_q [NUM_TABLES];
  logic [DATA_WIDTH-1:0] cor_data_q[NUM_TABLES];
  logic                  cor_ev_q  [NUM_TABLES];
  logic                  fwd_hit_q [NUM_TABLES];
  logic                  warm_q;
  logic [CNT_W-1:0]      fill_q;
  logic [CNT_W-1:0]      fill_nxt;

  // Candidate select: walk oldest to newest so the youngest match wins
  always_comb begin
    for (int t = 0; t < int'(NUM_TABLES); t++) begin
      sel_key[t]  = bus.rd_key_i[t];
      sel_data[t] = bus.rd_data_i[t];
      sel_ev[t]   = bus.rd_entry_valid_i[t];
      sel_hit[t]  = 1'b0;
      for (int k = int'(FORWARD_DEPTH) - 1; k >= 0; k--) begin
        if (hist_en[t][k] && (hist_adr[t][k] == bus.rd_adr_i[t])) begin
          sel_key[t]  = hist_key[t][k];
          sel_data[t] = hist_data[t][k];
          sel_ev[t]   = hist_ev[t][k];
          sel_hit[t]  = 1'b1;
        end
      end
      if ((BYPASS_CURRENT != 0) && bus.wr_en_i[t] && (bus.wr_adr_i[t] == bus.rd_adr_i[t])) begin
        sel_key[t]  = bus.wr_key_i[t];
        sel_data[t] = bus.wr_data_i[t];
        sel_ev[t]   = bus.wr_entry_valid_i[t];
        sel_hit[t]  = 1'b1;
      end
    end
  end

  // Next fill count; a flush restarts the window, and this enabled cycle counts as its first
  always_comb begin
    fill_nxt = fill_q;
    if (bus.flush_i) begin
      fill_nxt = CNT_W'(1);
    end else if (fill_q != FILL_MAX) begin
      fill_nxt = fill_q + CNT_W'(1);
    end
  end

  // History shift register; flush kills old entries but keeps a concurrent write visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < int'(NUM_TABLES); t++) begin
        for (int k = 0; k < int'(FORWARD_DEPTH); k++) begin
          hist_en[t][k]   <= 1'b0;
          hist_adr[t][k]  <= '0;
          hist_key[t][k]  <= '0;
          hist_data[t][k] <= '0;
          hist_ev[t][k]   <= 1'b0;
        end
      end
    end else begin
      for (int t = 0; t < int'(NUM_TABLES); t++) begin
        if (bus.clk_en) begin
          for (int k = 1; k < int'(FORWARD_DEPTH); k++) begin
            hist_en[t][k]   <= hist_en[t][k-1];
            hist_adr[t][k]  <= hist_adr[t][k-1];
            hist_key[t][k]  <= hist_key[t][k-1];
            hist_data[t][k] <= hist_data[t][k-1];
            hist_ev[t][k]   <= hist_ev[t][k-1];
          end
          hist_en[t][0]   <= bus.wr_en_i[t];
          hist_adr[t][0]  <= bus.wr_adr_i[t];
          hist_key[t][0]  <= bus.wr_key_i[t];
          hist_data[t][0] <= bus.wr_data_i[t];
          hist_ev[t][0]   <= bus.wr_entry_valid_i[t];
        end
        if (bus.flush_i) begin
          for (int k = 0; k < int'(FORWARD_DEPTH); k++) begin
            hist_en[t][k] <= 1'b0;
          end
          if (bus.clk_en) begin
            hist_en[t][0] <= bus.wr_en_i[t];
          end
        end
      end
    end
  end

  // Corrected output registers, fill counter and warm flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cor_valid_q <= 1'b0;
      warm_q      <= 1'b0;
      fill_q      <= '0;
      for (int t = 0; t < int'(NUM_TABLES); t++) begin
        cor_key_q[t]  <= '0;
        cor_data_q[t] <= '0;
        cor_ev_q[t]   <= 1'b0;
        fwd_hit_q[t]  <= 1'b0;
      end
    end else begin
      if (bus.clk_en) begin
        cor_valid_q <= bus.rd_valid_i;
        fill_q      <= fill_nxt;
        warm_q      <= (fill_nxt == FILL_MAX);
        for (int t = 0; t < int'(NUM_TABLES); t++) begin
          cor_key_q[t]  <= sel_key[t];
          cor_data_q[t] <= sel_data[t];
          cor_ev_q[t]   <= sel_ev[t];
          fwd_hit_q[t]  <= sel_hit[t];
        end
      end
      if (bus.flush_i) begin
        cor_valid_q <= 1'b0;
        for (int t = 0; t < int'(NUM_TABLES); t++) begin
          fwd_hit_q[t] <= 1'b0;
        end
        if (!bus.clk_en) begin
          fill_q <= '0;
          warm_q <= 1'b0;
        end
      end
    end
  end

  assign bus.cor_valid_o       = cor_valid_q;
  assign bus.cor_key_o         = cor_key_q;
  assign bus.cor_data_o        = cor_data_q;
  assign bus.cor_entry_valid_o = cor_ev_q;
  assign bus.fwd_hit_o         = fwd_hit_q;
  assign bus.warm_o            = warm_q;

`ifdef FWD_HIT_COUNT_EN
  logic [HIT_CNT_WIDTH-1:0] hit_cnt_q [NUM_TABLES];

  // Saturating count of consumed forwarded reads per table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < int'(NUM_TABLES); t++) begin
        hit_cnt_q[t] <= '0;
      end
    end else begin
      for (int t = 0; t < int'(NUM_TABLES); t++) begin
        if (bus.flush_i) begin
          hit_cnt_q[t] <= '0;
        end else if (bus.clk_en && bus.rd_valid_i && sel_hit[t] && (hit_cnt_q[t] != '1)) begin
          hit_cnt_q[t] <= hit_cnt_q[t] + HIT_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.fwd_hit_cnt_o = hit_cnt_q;
`endif
endmodule

// File: tb/tb_forward_hazard_window.sv
// Directed self-checking bench: one instance with same-cycle bypass, one without,
// both driven by identical stimulus.
module tb_forward_hazard_window;
  localparam int unsigned NT = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned KW = 8;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          flush;
  logic          rd_valid;
  logic [AW-1:0] rd_adr  [NT];
  logic [KW-1:0] rd_key  [NT];
  logic [DW-1:0] rd_data [NT];
  logic          rd_ev   [NT];
  logic          wr_en   [NT];
  logic [AW-1:0] wr_adr  [NT];
  logic [KW-1:0] wr_key  [NT];
  logic [DW-1:0] wr_data [NT];
  logic          wr_ev   [NT];

  int n_asserts = 0;
  int n_fail    = 0;

`ifdef FWD_HIT_COUNT_EN
  forward_hazard_window_if #(.NUM_TABLES(NT), .ADR_WIDTH(AW), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .HIT_CNT_WIDTH(8)) aif ();
  forward_hazard_window_if #(.NUM_TABLES(NT), .ADR_WIDTH(AW), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .HIT_CNT_WIDTH(8)) bif ();
`else
  forward_hazard_window_if #(.NUM_TABLES(NT), .ADR_WIDTH(AW), .KEY_WIDTH(KW), .DATA_WIDTH(DW)) aif ();
  forward_hazard_window_if #(.NUM_TABLES(NT), .ADR_WIDTH(AW), .KEY_WIDTH(KW), .DATA_WIDTH(DW)) bif ();
`endif

  assign aif.clk_en = clk_en;             assign bif.clk_en = clk_en;
  assign aif.flush_i = flush;             assign bif.flush_i = flush;
  assign aif.rd_valid_i = rd_valid;       assign bif.rd_valid_i = rd_valid;
  assign aif.rd_adr_i = rd_adr;           assign bif.rd_adr_i = rd_adr;
  assign aif.rd_key_i = rd_key;           assign bif.rd_key_i = rd_key;
  assign aif.rd_data_i = rd_data;         assign bif.rd_data_i = rd_data;
  assign aif.rd_entry_valid_i = rd_ev;    assign bif.rd_entry_valid_i = rd_ev;
  assign aif.wr_en_i = wr_en;             assign bif.wr_en_i = wr_en;
  assign aif.wr_adr_i = wr_adr;           assign bif.wr_adr_i = wr_adr;
  assign aif.wr_key_i = wr_key;           assign bif.wr_key_i = wr_key;
  assign aif.wr_data_i = wr_data;         assign bif.wr_data_i = wr_data;
  assign aif.wr_entry_valid_i = wr_ev;    assign bif.wr_entry_valid_i = wr_ev;

  forward_hazard_window #(
    .NUM_TABLES(NT), .FORWARD_DEPTH(3), .ADR_WIDTH(AW), .KEY_WIDTH(KW),
    .DATA_WIDTH(DW), .BYPASS_CURRENT(1), .HIT_CNT_WIDTH(8)
  ) dut_byp (.clk(clk), .reset(reset), .bus(aif));

  forward_hazard_window #(
    .NUM_TABLES(NT), .FORWARD_DEPTH(3), .ADR_WIDTH(AW), .KEY_WIDTH(KW),
    .DATA_WIDTH(DW), .BYPASS_CURRENT(0), .HIT_CNT_WIDTH(8)
  ) dut_nob (.clk(clk), .reset(reset), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush    = 1'b0;
    rd_valid = 1'b0;
    for (int t = 0; t < int'(NT); t++) begin
      rd_adr[t] = '0; rd_key[t] = '0; rd_data[t] = '0; rd_ev[t] = 1'b0;
      wr_en[t]  = 1'b0; wr_adr[t] = '0; wr_key[t] = '0; wr_data[t] = '0; wr_ev[t] = 1'b0;
    end
  endtask

  // One clock edge, then settle before checking and driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    clk_en = 1'b1;
    clear_inputs();
    rd_valid = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(aif.cor_valid_o), 32'h0);
    chk("rst_warm", 32'(aif.warm_o), 32'h0);
    chk("rst_hit0", 32'(aif.fwd_hit_o[0]), 32'h0);
    chk("rst_key0", 32'(aif.cor_key_o[0]), 32'h0);
    reset = 1'b1;
    rd_valid = 1'b0;

    // Warm-up: warm rises on the third enabled edge
    step(); chk("warm_1", 32'(aif.warm_o), 32'h0);
    chk("warm_1_valid", 32'(aif.cor_valid_o), 32'h0);
    step(); chk("warm_2", 32'(aif.warm_o), 32'h0);
    step(); chk("warm_3", 32'(aif.warm_o), 32'h1);

    // Age priority: two writes to the same address, the younger wins
    wr_en[1] = 1'b1; wr_adr[1] = 4'd5; wr_key[1] = 8'h11; wr_data[1] = 16'h0011; wr_ev[1] = 1'b1;
    step();
    wr_key[1] = 8'h22; wr_data[1] = 16'h0022;
    step();
    wr_en[1] = 1'b0;
    rd_valid = 1'b1;
    for (int t = 0; t < int'(NT); t++) rd_adr[t] = 4'd5;
    rd_key[0] = 8'h5A;
    step();
    chk("age_valid", 32'(aif.cor_valid_o), 32'h1);
    chk("age_key1", 32'(aif.cor_key_o[1]), 32'h22);
    chk("age_data1", 32'(aif.cor_data_o[1]), 32'h0022);
    chk("age_ev1", 32'(aif.cor_entry_valid_o[1]), 32'h1);
    chk("age_hit1", 32'(aif.fwd_hit_o[1]), 32'h1);
    chk("age_nob_key1", 32'(bif.cor_key_o[1]), 32'h22);
    chk("age_pass_key0", 32'(aif.cor_key_o[0]), 32'h5A);
    chk("age_pass_hit0", 32'(aif.fwd_hit_o[0]), 32'h0);

    // Window expiry: age 3 still forwards, age 4 falls out
    clear_inputs();
    wr_en[2] = 1'b1; wr_adr[2] = 4'd3; wr_key[2] = 8'hB3; wr_data[2] = 16'hBEEF; wr_ev[2] = 1'b1;
    step();
    wr_en[2] = 1'b0;
    step();
    step();
    rd_valid = 1'b1; rd_adr[2] = 4'd3; rd_data[2] = 16'h1234; rd_ev[2] = 1'b1;
    step();
    chk("exp_last_data", 32'(aif.cor_data_o[2]), 32'hBEEF);
    chk("exp_last_hit", 32'(aif.fwd_hit_o[2]), 32'h1);
    step();
    chk("exp_gone_data", 32'(aif.cor_data_o[2]), 32'h1234);
    chk("exp_gone_hit", 32'(aif.fwd_hit_o[2]), 32'h0);

    // Same-cycle delete: only the bypass instance sees it immediately
    clear_inputs();
    wr_en[3] = 1'b1; wr_adr[3] = 4'd7; wr_key[3] = 8'h77; wr_data[3] = 16'h7777; wr_ev[3] = 1'b0;
    rd_valid = 1'b1; rd_adr[3] = 4'd7; rd_key[3] = 8'h33; rd_data[3] = 16'h3333; rd_ev[3] = 1'b1;
    step();
    chk("byp_ev", 32'(aif.cor_entry_valid_o[3]), 32'h0);
    chk("byp_hit", 32'(aif.fwd_hit_o[3]), 32'h1);
    chk("byp_key", 32'(aif.cor_key_o[3]), 32'h77);
    chk("nob_ev", 32'(bif.cor_entry_valid_o[3]), 32'h1);
    chk("nob_hit", 32'(bif.fwd_hit_o[3]), 32'h0);
    chk("nob_key", 32'(bif.cor_key_o[3]), 32'h33);
    wr_en[3] = 1'b0;
    step();
    chk("del_age1_ev", 32'(aif.cor_entry_valid_o[3]), 32'h0);
    chk("del_age1_nob_ev", 32'(bif.cor_entry_valid_o[3]), 32'h0);
    chk("del_age1_nob_hit", 32'(bif.fwd_hit_o[3]), 32'h1);
    chk("del_age1_nob_data", 32'(bif.cor_data_o[3]), 32'h7777);

    // Stall: outputs and history frozen, writes during stall ignored
    clear_inputs();
    wr_en[0] = 1'b1; wr_adr[0] = 4'd9; wr_key[0] = 8'h99; wr_data[0] = 16'h0999; wr_ev[0] = 1'b1;
    rd_valid = 1'b1; rd_adr[0] = 4'd9; rd_key[0] = 8'h01;
    step();
    chk("stl_pre_key", 32'(aif.cor_key_o[0]), 32'h99);
    chk("stl_pre_nob_key", 32'(bif.cor_key_o[0]), 32'h01);
    clk_en = 1'b0;
    wr_key[0] = 8'hEE;
    rd_valid = 1'b0; rd_adr[0] = 4'd4;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stl_valid", 32'(aif.cor_valid_o), 32'h1);
      chk("stl_key", 32'(aif.cor_key_o[0]), 32'h99);
      chk("stl_hit", 32'(aif.fwd_hit_o[0]), 32'h1);
      chk("stl_warm", 32'(aif.warm_o), 32'h1);
    end
    clk_en = 1'b1;
    wr_en[0] = 1'b0;
    rd_valid = 1'b1; rd_adr[0] = 4'd9;
    step();
    chk("stl_resume_key", 32'(aif.cor_key_o[0]), 32'h99);
    chk("stl_resume_hit", 32'(aif.fwd_hit_o[0]), 32'h1);
    chk("stl_resume_nob_key", 32'(bif.cor_key_o[0]), 32'h99);
    chk("stl_resume_nob_hit", 32'(bif.fwd_hit_o[0]), 32'h1);

    // Flush with a concurrent write: old entries gone, new write survives
    flush = 1'b1;
    wr_en[0] = 1'b1; wr_adr[0] = 4'd2; wr_key[0] = 8'h2C; wr_data[0] = 16'h02C0; wr_ev[0] = 1'b1;
    step();
    chk("fl_valid", 32'(aif.cor_valid_o), 32'h0);
    chk("fl_hit", 32'(aif.fwd_hit_o[0]), 32'h0);
    chk("fl_warm", 32'(aif.warm_o), 32'h0);
    flush = 1'b0;
    wr_en[0] = 1'b0;
    step();
    chk("fl_old_key", 32'(aif.cor_key_o[0]), 32'h01);
    chk("fl_old_hit", 32'(aif.fwd_hit_o[0]), 32'h0);
    chk("fl_warm_2", 32'(aif.warm_o), 32'h0);
    chk("fl_valid_2", 32'(aif.cor_valid_o), 32'h1);
    rd_adr[0] = 4'd2; rd_key[0] = 8'h05;
    step();
    chk("fl_new_key", 32'(aif.cor_key_o[0]), 32'h2C);
    chk("fl_new_hit", 32'(aif.fwd_hit_o[0]), 32'h1);
    chk("fl_nob_new_key", 32'(bif.cor_key_o[0]), 32'h2C);
    chk("fl_warm_3", 32'(aif.warm_o), 32'h1);

    // Async reset between edges with a full history
    clear_inputs();
    wr_en[1] = 1'b1; wr_adr[1] = 4'd1; wr_key[1] = 8'h1F; wr_data[1] = 16'h0101; wr_ev[1] = 1'b1;
    rd_valid = 1'b1; rd_adr[1] = 4'd1; rd_key[1] = 8'h0A;
    step(); step(); step();
    chk("ar_pre_hit", 32'(aif.fwd_hit_o[1]), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(aif.cor_valid_o), 32'h0);
    chk("ar_hit", 32'(aif.fwd_hit_o[1]), 32'h0);
    chk("ar_key", 32'(aif.cor_key_o[1]), 32'h0);
    chk("ar_warm", 32'(aif.warm_o), 32'h0);
`ifdef FWD_HIT_COUNT_EN
    chk("ar_cnt0", 32'(aif.fwd_hit_cnt_o[0]), 32'h0);
    chk("ar_cnt1", 32'(aif.fwd_hit_cnt_o[1]), 32'h0);
`endif
    #1;
    reset = 1'b1;
    wr_en[1] = 1'b0;
    step();
    chk("ar_post_key", 32'(aif.cor_key_o[1]), 32'h0A);
    chk("ar_post_hit", 32'(aif.fwd_hit_o[1]), 32'h0);
    chk("ar_post_warm", 32'(aif.warm_o), 32'h0);

`ifdef FWD_HIT_COUNT_EN
    // Hit counter saturates at all-ones
    clear_inputs();
    wr_en[0] = 1'b1; wr_adr[0] = 4'd0; wr_key[0] = 8'h42; wr_ev[0] = 1'b1;
    rd_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("cnt_sat0", 32'(aif.fwd_hit_cnt_o[0]), 32'd255);
    chk("cnt_idle1", 32'(aif.fwd_hit_cnt_o[1]), 32'd0);
    flush = 1'b1;
    step();
    chk("cnt_flush0", 32'(aif.fwd_hit_cnt_o[0]), 32'd0);
    flush = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
